// File: rtl/vga_arb_pkg.sv
// -----------------------------------------------------------------------------
// vga_arb_pkg
// Shared types and defaults for the VGA frame-store write arbiter.
//   arbState_e      : arbiter FSM state (IDLE, GRANT, HOLD)
//   DW_DEF          : default pixel data width
//   MAX_BURST_DEF   : default maximum words per grant (one VGA line)
//   onehot_to_index : index of the set bit of a one-hot vector (up to 8 bits)
// -----------------------------------------------------------------------------
package vga_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arbState_e;

    localparam int DW_DEF        = 16;
    localparam int MAX_BURST_DEF = 640;

    // Returns the position of the set bit; 0 for an all-zero vector.
    function automatic logic [2:0] onehot_to_index(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_arbmod_if.sv
// -----------------------------------------------------------------------------
// vga_arbmod_if
// Bus between the drawing engines / frame store and the write arbiter.
//   iReq, iValid, iLast, iData : requester side (driven by the engines)
//   oGrant                     : one-hot grant, also the per-requester ready
//   oEn, oData                 : frame-store write port
//   oBusy, oCount              : grant held / words moved in current burst
//   oTimeout                   : forced-release pulse (VGA_ARBMOD_TIMEOUT_EN)
// Handshake: a word moves on a CLOCK edge where iValid[k] & oGrant[k] are
// both high; iData/iLast of requester k are only meaningful in that case.
// modports: master = engines/frame-store side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface vga_arbmod_if #(
    parameter int NUM_REQ = 3,
    parameter int DW      = 16,
    parameter int CW      = 10
);
    logic [NUM_REQ-1:0]    iReq;
    logic [NUM_REQ-1:0]    iValid;
    logic [NUM_REQ-1:0]    iLast;
    logic [NUM_REQ*DW-1:0] iData;
    logic [NUM_REQ-1:0]    oGrant;
    logic                  oEn;
    logic [DW-1:0]         oData;
    logic                  oBusy;
    logic [CW-1:0]         oCount;
`ifdef VGA_ARBMOD_TIMEOUT_EN
    logic                  oTimeout;
`endif

    modport master (
        output iReq, iValid, iLast, iData,
        input  oGrant, oEn, oData, oBusy, oCount
`ifdef VGA_ARBMOD_TIMEOUT_EN
        , input oTimeout
`endif
    );

    modport slave (
        input  iReq, iValid, iLast, iData,
        output oGrant, oEn, oData, oBusy, oCount
`ifdef VGA_ARBMOD_TIMEOUT_EN
        , output oTimeout
`endif
    );
endinterface

// File: rtl/vga_arbmod_rrpick.sv
// -----------------------------------------------------------------------------
// vga_rrpickmod
// Combinational round-robin picker. Searches iReq starting at iPtr+1
// (mod NUM_REQ), so the requester at iPtr has lowest priority.
//   iReq    : request vector
//   iPtr    : index of the most recently served requester
//   oWinOh  : one-hot winner (zero when nobody requests)
//   oWinIdx : winner index
//   oAny    : any request present
// -----------------------------------------------------------------------------
module vga_rrpickmod #(
    parameter int NUM_REQ = 3,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] iReq,
    input  logic [IW-1:0]      iPtr,
    output logic [NUM_REQ-1:0] oWinOh,
    output logic [IW-1:0]      oWinIdx,
    output logic               oAny
);
    int   cand;
    logic found;

    always_comb begin
        oWinOh  = '0;
        oWinIdx = '0;
        oAny    = |iReq;
        found   = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(iPtr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && iReq[IW'(cand)]) begin
                found               = 1'b1;
                oWinOh[IW'(cand)]   = 1'b1;
                oWinIdx             = IW'(cand);
            end
        end
    end
endmodule

// File: rtl/vga_arbmod.sv
// -----------------------------------------------------------------------------
// vga_arbmod
// Round-robin, burst-locked write arbiter in front of the vga_basemod write
// side. A granted requester keeps the single pixel write path until its burst
// ends (iLast or MAX_BURST words); then the pointer moves to it so it becomes
// lowest priority for the next pick.
// Ports:
//   CLOCK  : 100 MHz system clock
//   RESET  : asynchronous, active-high
//   bus    : vga_arbmod_if.slave (requests, data, grant, write port, status)
//   oState : current FSM state, for debug/checkers
// Optional: define VGA_ARBMOD_TIMEOUT_EN to add parameter TIMEOUT and the
// oTimeout output; a grant idle for TIMEOUT cycles is then force-released.
// Timing: iReq sampled in IDLE -> GRANT -> HOLD, oGrant visible 2 cycles after
// iReq. Each transfer shows up on oEn/oData one cycle later.
// -----------------------------------------------------------------------------
module vga_arbmod
    import vga_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CW        = 10
`ifdef VGA_ARBMOD_TIMEOUT_EN
    , parameter int TIMEOUT = 64
`endif
) (
    input  logic      CLOCK,
    input  logic      RESET,
    vga_arbmod_if.slave bus,
    output arbState_e oState
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_BURST);

    arbState_e          state, stateNext;
    logic [NUM_REQ-1:0] winOh, pickOhQ, grantQ;
    logic [IW-1:0]      winIdx, pickIdxQ, ptrQ, curIdx;
    logic               anyReq, xfer, lastHit, capHit, burstEnd;
    logic               enQ, busyQ;
    logic [DW-1:0]      dataQ, curData;
    logic [CW-1:0]      countQ;

    vga_rrpickmod #(.NUM_REQ(NUM_REQ), .IW(IW)) uPick (
        .iReq   (bus.iReq),
        .iPtr   (ptrQ),
        .oWinOh (winOh),
        .oWinIdx(winIdx),
        .oAny   (anyReq)
    );

    // Index of the current owner; only meaningful while grantQ is non-zero.
    assign curIdx  = IW'(onehot_to_index(8'(grantQ)));
    assign curData = bus.iData[int'(curIdx)*DW +: DW];
    assign xfer    = (state == HOLD) && |(bus.iValid & grantQ);
    assign lastHit = bus.iLast[curIdx];
    assign capHit  = (countQ == CNT_LAST);

`ifdef VGA_ARBMOD_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] idleCntQ;
    logic          timeoutHit, timeoutQ;

    assign timeoutHit = (state == HOLD) && !xfer && (idleCntQ == TW'(TIMEOUT - 1));
    assign burstEnd   = (xfer && (lastHit || capHit)) || timeoutHit;

    // Cycles in HOLD since the last transfer.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            idleCntQ <= '0;
            timeoutQ <= 1'b0;
        end else begin
            timeoutQ <= timeoutHit;
            if (state != HOLD || xfer) idleCntQ <= '0;
            else                       idleCntQ <= idleCntQ + 1'b1;
        end
    end
    assign bus.oTimeout = timeoutQ;
`else
    assign burstEnd = xfer && (lastHit || capHit);
`endif

    // FSM state register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= stateNext;
    end

    // FSM next state.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyReq) stateNext = GRANT;
            GRANT:   stateNext = HOLD;
            HOLD:    if (burstEnd) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Grant, pointer, counter and write-port pipeline.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            pickOhQ  <= '0;
            pickIdxQ <= '0;
            grantQ   <= '0;
            ptrQ     <= '0;
            busyQ    <= 1'b0;
            countQ   <= '0;
            enQ      <= 1'b0;
            dataQ    <= '0;
        end else begin
            enQ <= xfer;
            if (xfer) dataQ <= curData;

            if (state == IDLE && anyReq) begin
                pickOhQ  <= winOh;
                pickIdxQ <= winIdx;
            end

            if (state == GRANT) begin
                grantQ <= pickOhQ;
                busyQ  <= 1'b1;
                countQ <= '0;
            end else if (xfer && countQ != CNT_SAT) begin
                countQ <= countQ + 1'b1;
            end

            if (burstEnd) begin
                grantQ <= '0;
                busyQ  <= 1'b0;
                ptrQ   <= pickIdxQ;
            end
        end
    end

    assign bus.oGrant = grantQ;
    assign bus.oEn    = enQ;
    assign bus.oData  = dataQ;
    assign bus.oBusy  = busyQ;
    assign bus.oCount = countQ;
    assign oState     = state;
endmodule

// File: tb/tb_vga_arbmod.sv
// -----------------------------------------------------------------------------
// tb_vga_arbmod
// Directed bench for vga_arbmod with NUM_REQ=3, DW=16, MAX_BURST=8, CW=4
// (TIMEOUT=16 when VGA_ARBMOD_TIMEOUT_EN is defined). Inputs are driven 1 ns
// after the rising edge; outputs are checked at the same point, and written
// words are checked at the falling edge against an expected-data queue.
// -----------------------------------------------------------------------------
module tb_vga_arbmod;
    import vga_arb_pkg::*;

    localparam int NR = 3;
    localparam int W  = 16;

    logic      CLOCK;
    logic      RESET;
    arbState_e dbgState;

    int nCompared   = 0;
    int nMismatched = 0;
    int enCount     = 0;
    logic [W-1:0] exp_q[$];

    vga_arbmod_if #(.NUM_REQ(NR), .DW(W), .CW(4)) bus ();

    vga_arbmod #(
        .NUM_REQ(NR), .DW(W), .MAX_BURST(8), .CW(4)
`ifdef VGA_ARBMOD_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus.slave),
        .oState(dbgState)
    );

    // ---------------- clock ----------------
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard on the frame-store write port.
    always @(negedge CLOCK) begin
        if (bus.oEn === 1'b1) begin
            enCount++;
            if (exp_q.size() == 0) chk("wr_unexpected", 32'(bus.oData), 32'hFFFF_FFFF);
            else                   chk("wr_data", 32'(bus.oData), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic setData(input int k, input logic [W-1:0] d);
        bus.iData[k*W +: W] = d;
    endtask

    task automatic doReset();
        RESET      = 1'b1;
        bus.iReq   = '0;
        bus.iValid = '0;
        bus.iLast  = '0;
        bus.iData  = '0;
        repeat (2) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
    endtask

    // Present one word from requester k (caller knows k holds the grant).
    task automatic sendWord(input int k, input logic [W-1:0] d, input logic last);
        bus.iValid[k] = 1'b1;
        bus.iLast[k]  = last;
        setData(k, d);
        exp_q.push_back(d);
        tick();
        bus.iValid[k] = 1'b0;
        bus.iLast[k]  = 1'b0;
    endtask

    // Wait (bounded) for any grant, then check it is requester k.
    task automatic waitGrant(input int k, output int cycles);
        cycles = 0;
        while (bus.oGrant == '0 && cycles < 20) begin
            tick();
            cycles++;
        end
        chk("grant_owner", 32'(bus.oGrant), 32'(1 << k));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int enBase;
        logic [2:0] vpat [5];
        vpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        doReset();
        chk("rst_grant", 32'(bus.oGrant), 0);
        chk("rst_en",    32'(bus.oEn),    0);
        chk("rst_data",  32'(bus.oData),  0);
        chk("rst_busy",  32'(bus.oBusy),  0);
        chk("rst_count", 32'(bus.oCount), 0);
        chk("rst_state", 32'(dbgState),   32'(IDLE));

        // Single requester, 4-word burst
        enBase   = enCount;
        bus.iReq = 3'b001;
        tick();
        chk("t1_state_grant", 32'(dbgState), 32'(GRANT));
        chk("t1_grant_early", 32'(bus.oGrant), 0);
        tick();
        chk("t1_grant", 32'(bus.oGrant), 32'h1);
        chk("t1_busy",  32'(bus.oBusy),  1);
        chk("t1_count0", 32'(bus.oCount), 0);
        bus.iReq = '0;
        for (int i = 0; i < 4; i++) begin
            sendWord(0, 16'h1111 * 16'(i + 1), i == 3);
            chk("t1_en",    32'(bus.oEn),    1);
            chk("t1_count", 32'(bus.oCount), 32'(i + 1));
        end
        chk("t1_grant_drop", 32'(bus.oGrant), 0);
        chk("t1_busy_drop",  32'(bus.oBusy),  0);
        chk("t1_state_idle", 32'(dbgState),   32'(IDLE));
        tick();
        chk("t1_en_low",  32'(bus.oEn), 0);
        chk("t1_en_total", 32'(enCount - enBase), 4);

        // Round-robin fairness: order 1,2,0,1,2,0; grant visible 2 cycles after release
        doReset();
        bus.iReq = 3'b111;
        for (int r = 0; r < 6; r++) begin
            waitGrant((r + 1) % 3, cyc);
            chk("rr_gap", 32'(cyc), 2);
            sendWord((r + 1) % 3, 16'h2000 + 16'(r * 2), 1'b0);
            sendWord((r + 1) % 3, 16'h2001 + 16'(r * 2), 1'b1);
            chk("rr_release", 32'(bus.oGrant), 0);
        end
        bus.iReq = '0;
        tick();

        // Burst cap at 8 words, requester 0 streams 12 words without iLast
        enBase   = enCount;
        bus.iReq = 3'b001;
        waitGrant(0, cyc);
        for (int i = 0; i < 8; i++) sendWord(0, 16'h3000 + 16'(i), 1'b0);
        chk("cap_release", 32'(bus.oGrant), 0);
        chk("cap_count",   32'(bus.oCount), 8);
        tick();
        chk("cap_en_8", 32'(enCount - enBase), 8);
        waitGrant(0, cyc);
        bus.iReq = '0;
        for (int i = 8; i < 12; i++) sendWord(0, 16'h3000 + 16'(i), i == 11);
        chk("cap_count2", 32'(bus.oCount), 4);
        tick();
        chk("cap_en_12", 32'(enCount - enBase), 12);

        // Valid gaps while non-granted requesters hold valid high
        doReset();
        enBase   = enCount;
        bus.iReq = 3'b010;
        waitGrant(1, cyc);
        bus.iReq = '0;
        setData(0, 16'hDEAD);
        setData(2, 16'hBEEF);
        for (int i = 0; i < 5; i++) begin
            bus.iValid = vpat[i][0] ? 3'b111 : 3'b101;
            bus.iLast  = (i == 4) ? 3'b111 : 3'b101;
            if (vpat[i][0]) begin
                setData(1, 16'hA000 + 16'(i));
                exp_q.push_back(16'hA000 + 16'(i));
            end
            tick();
            chk("gap_en", 32'(bus.oEn), 32'(vpat[i][0]));
        end
        bus.iValid = '0;
        bus.iLast  = '0;
        chk("gap_count", 32'(bus.oCount), 3);
        chk("gap_release", 32'(bus.oGrant), 0);
        tick();
        chk("gap_en_total", 32'(enCount - enBase), 3);

        // Asynchronous reset after 3 of 6 words
        doReset();
        enBase   = enCount;
        bus.iReq = 3'b100;
        waitGrant(2, cyc);
        bus.iReq = '0;
        for (int i = 0; i < 3; i++) sendWord(2, 16'h5000 + 16'(i), 1'b0);
        chk("ar_en_before", 32'(bus.oEn), 1);
        @(negedge CLOCK);
        #1;
        RESET = 1'b1;
        #1;
        chk("ar_grant", 32'(bus.oGrant), 0);
        chk("ar_en",    32'(bus.oEn),    0);
        chk("ar_busy",  32'(bus.oBusy),  0);
        chk("ar_state", 32'(dbgState),   32'(IDLE));
        bus.iReq = 3'b110;
        #1;
        RESET = 1'b0;
        waitGrant(1, cyc);
        chk("ar_regrant_gap", 32'(cyc), 2);
        bus.iReq = '0;
        sendWord(1, 16'h5555, 1'b1);
        tick();
        chk("ar_en_total", 32'(enCount - enBase), 4);

`ifdef VGA_ARBMOD_TIMEOUT_EN
        // Idle grant force-released after 16 cycles without a transfer
        doReset();
        bus.iReq = 3'b001;
        waitGrant(0, cyc);
        bus.iReq = 3'b010;
        repeat (15) tick();
        chk("to_held",     32'(bus.oGrant),   32'h1);
        chk("to_no_pulse", 32'(bus.oTimeout), 0);
        tick();
        chk("to_pulse",   32'(bus.oTimeout), 1);
        chk("to_release", 32'(bus.oGrant),   0);
        tick();
        chk("to_pulse_end", 32'(bus.oTimeout), 0);
        chk("to_not_yet",   32'(bus.oGrant),   0);
        tick();
        chk("to_next_grant", 32'(bus.oGrant), 32'h2);
        bus.iReq = '0;
        sendWord(1, 16'h6666, 1'b1);
        tick();
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/vga_arbmod.md
Name: vga_arbmod

Overview:
- Write-port arbiter for the VGA frame store.
- Shares the single sequential pixel write path (16-bit data plus write enable into the save/basemod write side) among NUM_REQ drawing engines.
- Round-robin grant, burst-locked: a granted requester owns the path until its burst ends.
- Sits between the drawing engines and vga_basemod iEn/iData; all logic on the 100 MHz CLOCK domain.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DW, 16, pixel data width.
- MAX_BURST, 640, maximum words per grant (one VGA line).
- CW, 10, burst counter width; must satisfy 2^CW > MAX_BURST.

Ports:
- CLOCK  input  1  system clock, 100 MHz.
- RESET  input  1  asynchronous, active-high reset.
- iReq  input  NUM_REQ  per-requester bus request; level-held until granted.
- iValid  input  NUM_REQ  per-requester data valid.
- iLast  input  NUM_REQ  marks final word of burst; qualified by iValid.
- iData  input  NUM_REQ*DW  packed requester data; requester k at [k*DW +: DW].
- oGrant  output  NUM_REQ  one-hot grant; doubles as per-requester ready.
- oEn  output  1  write enable to frame store.
- oData  output  DW  write data to frame store.
- oBusy  output  1  high while any grant is held.
- oCount  output  CW  words transferred in current burst.

Behaviour:
- Clock and reset: one clock (CLOCK); RESET is asynchronous and active-high.
- Reset values: oGrant=0, oEn=0, oData=0, oBusy=0, oCount=0, state=IDLE, RR pointer=0.
- FSM states: IDLE, GRANT, HOLD.
- IDLE: when any iReq bit is set, select the first requester at or after pointer+1 (mod NUM_REQ); after reset that is requester 1 when it is requesting. Go to GRANT. No request: stay in IDLE.
- GRANT: assert oGrant[k] and oBusy; clear oCount; go to HOLD. Latency is 2 cycles from iReq sampled in IDLE to oGrant visible.
- HOLD, transfer: a transfer is iValid[k] & oGrant[k] on a clock edge.
  - Each transfer registers oData=iData[k] and oEn=1 next cycle (1-cycle pipeline), and increments oCount.
  - oEn=0 on any cycle without a transfer on the previous edge.
  - Other requesters' iValid is ignored.
- Burst end: iLast[k] with a transfer, or oCount reaching MAX_BURST-1 with a transfer.
  - Drop oGrant next cycle, set pointer=k, return to IDLE.
  - One idle cycle minimum between grants, so there are no back-to-back grants.
- iReq[k] deasserted during HOLD without iLast: grant held; only burst end releases it.
- MAX_BURST truncation: the word transferred at count MAX_BURST-1 is the last accepted. A later iLast from that requester is treated as part of a new burst.
- Simultaneous iLast and count limit: a single release.
- Pointer wrap: NUM_REQ-1 wraps to 0.
- Requester re-requesting immediately after release: goes lowest priority and is served only if no other requester is active.
- RESET mid-burst: all outputs clear asynchronously; the partial burst is abandoned and the frame store sees no further oEn.
- oCount saturates at MAX_BURST and never wraps.

Optional Feature:
- Macro: VGA_ARBMOD_TIMEOUT_EN.
- With it: parameter TIMEOUT (default 64) and an idle counter in HOLD.
  - The counter is reset on each transfer.
  - When it reaches TIMEOUT-1 with no transfer, the grant is released exactly as a burst end (pointer=k, back to IDLE).
  - Adds output oTimeout, a 1-cycle pulse on forced release.
- Without it: a grant is held indefinitely until iLast or MAX_BURST; no oTimeout port, no counter logic.

Decomposition:
- Package vga_arb_pkg:
  - state enum (IDLE, GRANT, HOLD);
  - DW default;
  - MAX_BURST default;
  - function onehot_to_index.
- One sub-module, vga_rrpickmod: combinational round-robin picker taking the iReq vector and pointer, returning a one-hot winner and its index. The FSM, counters and data mux stay in vga_arbmod.

Test Plan:
- Single requester: iReq=3'b001, burst of 4 words 0x1111..0x4444 with iLast on the 4th. Required: oGrant=001 two cycles after iReq; oEn high 4 cycles, each one cycle after its transfer; oData 0x1111..0x4444; oCount ends at 4; oGrant drops the cycle after the last transfer.
- Round-robin fairness: iReq=111 held constantly, 2-word bursts. Required grant order after reset is 1, 2, 0, 1, 2, 0, with one idle cycle between grants.
- Burst cap: MAX_BURST=8, requester 0 streams 12 words without iLast. Required: exactly 8 oEn pulses, then release. The remaining 4 words are accepted in a fresh grant, or after other requesters are served.
- Gaps and foreign valid: iValid[k] toggled 1-0-1 while iValid of non-granted requesters is high. Required: oEn only for the granted requester's valid cycles; oCount counts only those.
- Async reset mid-burst: RESET pulsed after 3 of 6 words. Required: oGrant, oEn and oBusy fall immediately; state is IDLE; the next grant after release of RESET goes to requester 1 when it is requesting.
- VGA_ARBMOD_TIMEOUT_EN with TIMEOUT=16: grant held with no valid for 16 cycles. Required: a oTimeout pulse, grant released, the next requester granted 2 cycles later.
